dice_display_scan_ctrl: RTL and testbench

- Time-multiplexes the shared 7-segment bus (uo_out[7:0]) between the ones and tens digit commons (uio_out[3], uio_out[4]).
- Applies PWM brightness from I2C register 8, bits [6:0], giving a duty of N/128.
- Sits between the dice result registers (digit1/digit10), the I2C register file and the pad muxing in the top level.
- Owns all pad polarity handling for the segments and the commons.

---
 rtl/dice_display_scan_ctrl_if.sv | 23 ++
 rtl/dice_display_scan_ctrl.sv | 75 +++++++
 tb/tb_dice_display_scan_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/dice_display_scan_ctrl_if.sv
// Display scan bus: the dice and register-file values going in, the segment and common pads coming out.
// Inputs are plain levels and are sampled by the controller only at slot boundaries, apart from the two polarity bits.
interface dice_display_scan_ctrl_if;
    logic [3:0] digit1;
    logic [3:0] digit10;
    logic [6:0] brightness;
    logic       seg_pol;
    logic       com_pol;
    logic [7:0] seg;
    logic       com1;
    logic       com10;
    logic [1:0] com_oe;

    modport master (
        output digit1, digit10, brightness, seg_pol, com_pol,
        input  seg, com1, com10, com_oe
    );

    modport slave (
        input  digit1, digit10, brightness, seg_pol, com_pol,
        output seg, com1, com10, com_oe
    );
endinterface

// File: rtl/dice_display_scan_ctrl.sv
// Two-digit 7-segment scan controller with PWM brightness and pad polarity handling.
// Each digit slot is 128 PWM steps; phase 0 is always dark so the commons never overlap at the swap.
module dice_display_scan_ctrl #(
    parameter int PRESCALE = 4,
    parameter bit LZ_BLANK = 1'b1
) (
    input logic clk,
    input logic rst,
    dice_display_scan_ctrl_if.slave bus
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic {SLOT_ONES = 1'b0, SLOT_TENS = 1'b1} slot_t;

    logic [PW-1:0] pre;
    logic [6:0]    phase;
    slot_t         slot;
    logic [6:0]    lat_duty;
    logic [3:0]    lat_digit;
    logic          tick;
    logic          on;
    logic [6:0]    pattern;

    assign tick = (pre == PW'(PRESCALE - 1));
    assign on   = (phase != 7'd0) && (phase <= lat_duty);

    always_comb begin
        pattern = 7'h00;
        case (lat_digit)
            4'd0: pattern = 7'h3f;
            4'd1: pattern = 7'h06;
            4'd2: pattern = 7'h5b;
            4'd3: pattern = 7'h4f;
            4'd4: pattern = 7'h66;
            4'd5: pattern = 7'h6d;
            4'd6: pattern = 7'h7d;
            4'd7: pattern = 7'h07;
            4'd8: pattern = 7'h7f;
            4'd9: pattern = 7'h6f;
            default: pattern = 7'h00;
        endcase
        if (LZ_BLANK && slot == SLOT_TENS && lat_digit == 4'd0) begin
            pattern = 7'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre        <= '0;
            phase      <= 7'd0;
            slot       <= SLOT_ONES;
            lat_duty   <= 7'd0;
            lat_digit  <= 4'd15;
            bus.seg    <= {8{~bus.seg_pol}};
            bus.com1   <= ~bus.com_pol;
            bus.com10  <= ~bus.com_pol;
            bus.com_oe <= 2'b00;
        end else begin
            pre <= tick ? '0 : pre + 1'b1;
            if (tick) begin
                phase <= phase + 7'd1;
                // Inputs are captured only here so a slot is never torn.
                if (phase == 7'd127) begin
                    slot      <= (slot == SLOT_ONES) ? SLOT_TENS : SLOT_ONES;
                    lat_duty  <= bus.brightness;
                    lat_digit <= (slot == SLOT_TENS) ? bus.digit1 : bus.digit10;
                end
            end
            bus.seg    <= on ? ({1'b0, pattern} ^ {8{~bus.seg_pol}}) : {8{~bus.seg_pol}};
            bus.com1   <= (on && slot == SLOT_ONES) ? bus.com_pol : ~bus.com_pol;
            bus.com10  <= (on && slot == SLOT_TENS) ? bus.com_pol : ~bus.com_pol;
            bus.com_oe <= 2'b11;
        end
    end
endmodule

// File: tb/tb_dice_display_scan_ctrl.sv
// Slot-by-slot check of the scan controller with PRESCALE=1: every output sample of every slot is compared.
module tb_dice_display_scan_ctrl;
  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  dice_display_scan_ctrl_if bus ();

  dice_display_scan_ctrl #(.PRESCALE(1), .LZ_BLANK(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record per 128-cycle slot: the values latched for it, its polarity, and what it must show.
  typedef struct {
    logic [6:0] bri;
    logic [3:0] d1;
    logic [3:0] d10;
    logic       sp;
    logic       cp;
    int         duty;
    logic       tens;
    logic [7:0] seg_on;
  } row_t;

  row_t vec[18];

  function automatic row_t mk(logic [6:0] bri, logic [3:0] d1, logic [3:0] d10, logic sp,
                              logic cp, int duty, logic tens, logic [7:0] seg_on);
    row_t r;
    r.bri = bri; r.d1 = d1; r.d10 = d10; r.sp = sp; r.cp = cp;
    r.duty = duty; r.tens = tens; r.seg_on = seg_on;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 30) $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; leaves at a negedge after 128 samples.
  task automatic run_slot(input int idx, input row_t rw, input row_t nx);
    int   act;
    logic on;
    logic [7:0] e_seg;
    logic e_c1, e_c10;
    act = 0;
    for (int j = 0; j < 128; j++) begin
      if (j == 0) begin
        bus.seg_pol = rw.sp;
        bus.com_pol = rw.cp;
      end
      if (j == 64) begin
        bus.brightness = nx.bri;
        bus.digit1     = nx.d1;
        bus.digit10    = nx.d10;
      end
      @(posedge clk);
      #1;
      on    = (j != 0) && (j <= rw.duty);
      e_seg = on ? rw.seg_on : {8{~rw.sp}};
      e_c1  = (on && !rw.tens) ? rw.cp : ~rw.cp;
      e_c10 = (on && rw.tens) ? rw.cp : ~rw.cp;
      chk($sformatf("slot%0d step%0d {oe,c1,c10,seg}", idx, j),
          {20'd0, bus.com_oe, bus.com1, bus.com10, bus.seg},
          {20'd0, 2'b11, e_c1, e_c10, e_seg});
      if ((rw.tens ? bus.com10 : bus.com1) == rw.cp) act++;
      @(negedge clk);
    end
    chk($sformatf("slot%0d active_count", idx), act, rw.duty);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    vec[0]  = mk(7'h2b, 4'd7,  4'd4, 1'b1, 1'b0, 0,   1'b0, 8'h00);
    vec[1]  = mk(7'h2b, 4'd7,  4'd4, 1'b1, 1'b0, 43,  1'b1, 8'h66);
    vec[2]  = mk(7'h2b, 4'd7,  4'd4, 1'b1, 1'b0, 43,  1'b0, 8'h07);
    vec[3]  = mk(7'h2b, 4'd7,  4'd4, 1'b1, 1'b0, 43,  1'b1, 8'h66);
    vec[4]  = mk(7'h01, 4'd7,  4'd4, 1'b1, 1'b0, 1,   1'b0, 8'h07);
    vec[5]  = mk(7'h7f, 4'd7,  4'd4, 1'b1, 1'b0, 127, 1'b1, 8'h66);
    vec[6]  = mk(7'h7f, 4'd7,  4'd4, 1'b1, 1'b0, 127, 1'b0, 8'h07);
    vec[7]  = mk(7'h00, 4'd7,  4'd4, 1'b1, 1'b0, 0,   1'b1, 8'h00);
    vec[8]  = mk(7'h00, 4'd7,  4'd4, 1'b1, 1'b0, 0,   1'b0, 8'h00);
    vec[9]  = mk(7'h00, 4'd7,  4'd4, 1'b1, 1'b0, 0,   1'b1, 8'h00);
    vec[10] = mk(7'h00, 4'd7,  4'd4, 1'b1, 1'b0, 0,   1'b0, 8'h00);
    vec[11] = mk(7'h20, 4'd12, 4'd0, 1'b1, 1'b0, 32,  1'b1, 8'h00);
    vec[12] = mk(7'h20, 4'd12, 4'd0, 1'b1, 1'b0, 32,  1'b0, 8'h00);
    vec[13] = mk(7'h20, 4'd2,  4'd9, 1'b0, 1'b1, 32,  1'b1, 8'h90);
    vec[14] = mk(7'h20, 4'd2,  4'd9, 1'b0, 1'b1, 32,  1'b0, 8'ha4);
    vec[15] = mk(7'h05, 4'd3,  4'd8, 1'b1, 1'b0, 5,   1'b1, 8'h7f);
    vec[16] = mk(7'h7f, 4'd5,  4'd6, 1'b1, 1'b0, 127, 1'b0, 8'h6d);
    vec[17] = mk(7'h7f, 4'd5,  4'd6, 1'b1, 1'b0, 127, 1'b1, 8'h7d);

    rst = 1'b1;
    bus.brightness = vec[0].bri;
    bus.digit1     = vec[0].d1;
    bus.digit10    = vec[0].d10;
    bus.seg_pol    = vec[0].sp;
    bus.com_pol    = vec[0].cp;
    repeat (3) @(posedge clk);
    #1;
    chk("reset {oe,c1,c10,seg}", {20'd0, bus.com_oe, bus.com1, bus.com10, bus.seg},
        {20'd0, 2'b00, 1'b1, 1'b1, 8'h00});
    @(negedge clk);
    rst = 1'b0;

    for (int r = 0; r < 18; r++) begin
      run_slot(r, vec[r], (r < 17) ? vec[r + 1] : vec[17]);
    end

    // Reset around phase 60 with a bright setting pending: the restarted first slot must still be dark.
    bus.brightness = 7'h7f;
    bus.digit1     = 4'd8;
    bus.digit10    = 4'd1;
    repeat (60) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midslot_reset {oe,c1,c10,seg}", {20'd0, bus.com_oe, bus.com1, bus.com10, bus.seg},
        {20'd0, 2'b00, 1'b1, 1'b1, 8'h00});
    @(negedge clk);
    rst = 1'b0;
    run_slot(100, mk(7'h7f, 4'd8, 4'd1, 1'b1, 1'b0, 0, 1'b0, 8'h00),
             mk(7'h7f, 4'd8, 4'd1, 1'b1, 1'b0, 127, 1'b1, 8'h06));
    run_slot(101, mk(7'h7f, 4'd8, 4'd1, 1'b1, 1'b0, 127, 1'b1, 8'h06),
             mk(7'h7f, 4'd8, 4'd1, 1'b1, 1'b0, 127, 1'b1, 8'h06));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
